fpu_share_scheduler: RTL
========================

// Module: fpu_share_scheduler
// PURPOSE
//  Shares one floating_alu instance between NUM_REQ requesters (e.g. per-warp/lane issue slots).
//  Takes requests over a valid/ready handshake and arbitrates round-robin.
//  Holds the operands stable, drives alu_enable for one cycle, then waits a fixed ALU_LATENCY.
//  Returns the captured result tagged with the requester id; one op is in flight at a time.
// PARAMETERS
//  NUM_REQ      4  number of requesters, >=1
//  ID_W         2  width of resp_id, = max(1,$clog2(NUM_REQ))
//  ALU_LATENCY  1  cycles from the alu_enable edge until alu_result is valid, >=1
// PORTS
//  clk              in   1              rising-edge clock
//  reset            in   1              asynchronous, active-high reset
//  req_valid        in   NUM_REQ        per-requester request valid
//  req_ready        out  NUM_REQ        one-hot grant; handshake when valid&ready
//  req_op1          in   NUM_REQ*32     operand 1, slice [i*32+:32]
//  req_op2          in   NUM_REQ*32     operand 2, slice [i*32+:32]
//  req_instr        in   NUM_REQ*$bits(alu_instruction_t)  per-requester opcode
//  alu_enable       out  1              one-cycle pulse to floating_alu
//  alu_op1/alu_op2  out  32             operands to floating_alu
//  alu_instruction  out  alu_instruction_t  opcode to floating_alu
//  alu_result       in   32             floating_alu result
//  resp_valid       out  1              result available
//  resp_ready       in   1              consumer accepts the result
//  resp_id          out  ID_W           index of the requester that owns resp_data
//  resp_data        out  32             captured result
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr_ptr=0, cnt=0, all outputs 0 (alu_instruction = 0 encoding).
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
//    - req_ready[grant]=1 combinationally, only in IDLE; all other req_ready bits are 0.
//    - On grant: latch op1/op2/instr/grant id into hold regs, go to ISSUE. No valid bit set: stay in IDLE.
//  - ISSUE: alu_enable=1 for exactly this cycle. Load cnt=ALU_LATENCY, go to WAIT.
//  - WAIT: cnt decrements each cycle. When cnt==1, capture alu_result into resp_data and go to RESP.
//  - alu_op1/alu_op2/alu_instruction are driven from the hold regs in ISSUE/WAIT/RESP; they are stable for the whole op.
//  - RESP: resp_valid=1 with resp_id and resp_data stable until resp_ready.
//    - On resp_valid&resp_ready: rr_ptr = (resp_id+1) mod NUM_REQ, go to IDLE.
//    - A new grant occurs no earlier than the next cycle.
//  - Latency, handshake to resp_valid: ALU_LATENCY+1 cycles. Minimum op period: ALU_LATENCY+3 cycles.
//  - resp_ready is ignored outside RESP. req_valid deasserted after a handshake has no effect.
//  - Requester changing operands while req_valid&!req_ready: the value latched is the one present in the grant cycle.
//  - rr_ptr wrap: NUM_REQ-1 -> 0. NUM_REQ=1: always grant 0, rr_ptr stays 0.
//  - Reset mid-op (any state): in-flight op discarded, no response issued, alu_enable forced 0 immediately.
//    - floating_alu clears on its own synchronous reset.
//  - Opcode is not decoded here; every alu_instruction_t value is passed through unchanged.
// STRUCTURE
//  - common.sv package gets:
//    - typedef enum logic [1:0] {SCH_IDLE, SCH_ISSUE, SCH_WAIT, SCH_RESP} fpu_sched_state_t
//    - localparam FPU_DATA_W = 32
//  - alu_instruction_t is reused from common.sv.
//  - One sub-module: rr_arbiter #(NUM_REQ) (req, ptr -> one-hot gnt, gnt_id), purely combinational.
//  - FSM, hold regs and counter stay in fpu_share_scheduler.
//  - floating_alu is instantiated by the parent, not inside this block.
// TESTING
//  - Single op: req_valid=0001, FADD 0x3F800000,0x40000000, ALU model returns 0x40400000
//    -> one alu_enable pulse; resp_valid with resp_id=0, resp_data=0x40400000 after ALU_LATENCY+1 cycles.
//  - Fairness: req_valid=1111 held, resp_ready=1 -> grant order 0,1,2,3,0.
//    - Each requester gets exactly one grant per 4 ops.
//  - Backpressure: resp_ready=0 for 10 cycles in RESP
//    -> resp_valid/resp_id/resp_data constant, req_ready all 0, no alu_enable.
//  - ALU_LATENCY=3: alu_result toggles garbage until cycle 3 after enable
//    -> resp_data equals the cycle-3 value, handshake to resp_valid = 4 cycles.
//  - Async reset asserted mid-WAIT -> outputs 0 within the same cycle.
//    - After release: IDLE, rr_ptr=0, no stray resp_valid.
//  - Stall skip: req_valid=1010, rr_ptr=0 -> grant 1, then 3, then 1. NUM_REQ=1 build: repeated grants to 0.

Source files
------------

// File: rtl/fpu_share_scheduler_pkg.sv
// Shared types for the FPU share scheduler: ALU opcode, scheduler state and data width.
package fpu_share_scheduler_pkg;

   localparam int unsigned FPU_DATA_W = 32;

   typedef enum logic [2:0] {
      FADD,
      FSUB,
      FMUL,
      FDIV,
      FMIN,
      FMAX,
      FSQRT,
      FCMP
   } alu_instruction_t;

   typedef enum logic [1:0] {
      SCH_IDLE,
      SCH_ISSUE,
      SCH_WAIT,
      SCH_RESP
   } fpu_sched_state_t;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpu_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping to 0.
module rr_arbiter
   import fpu_share_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               any_gnt
);

   always_comb begin
      logic [ID_W-1:0] sel;
      gnt     = '0;
      gnt_id  = '0;
      any_gnt = 1'b0;
      sel     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sel = ID_W'((32'(ptr) + k) % NUM_REQ);
         if (!any_gnt && req[sel]) begin
            any_gnt  = 1'b1;
            gnt[sel] = 1'b1;
            gnt_id   = sel;
         end
      end
   end

endmodule

// File: rtl/fpu_share_scheduler.sv
// Shares one floating_alu among NUM_REQ requesters, one op in flight, round-robin grants,
// fixed ALU latency, result returned with the owning requester id.
module fpu_share_scheduler
   import fpu_share_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ID_W        = id_width(NUM_REQ),
   parameter int unsigned ALU_LATENCY = 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ*FPU_DATA_W-1:0]          req_op1,
   input  logic [NUM_REQ*FPU_DATA_W-1:0]          req_op2,
   input  logic [NUM_REQ*$bits(alu_instruction_t)-1:0] req_instr,
   output logic                                   alu_enable,
   output logic [FPU_DATA_W-1:0]                  alu_op1,
   output logic [FPU_DATA_W-1:0]                  alu_op2,
   output alu_instruction_t                       alu_instruction,
   input  logic [FPU_DATA_W-1:0]                  alu_result,
   output logic                                   resp_valid,
   input  logic                                   resp_ready,
   output logic [ID_W-1:0]                        resp_id,
   output logic [FPU_DATA_W-1:0]                  resp_data
);

   localparam int unsigned IW    = $bits(alu_instruction_t);
   localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 1);

   fpu_sched_state_t state;
   logic [ID_W-1:0]       rr_ptr;
   logic [CNT_W-1:0]      cnt;
   logic [FPU_DATA_W-1:0] op1_q;
   logic [FPU_DATA_W-1:0] op2_q;
   alu_instruction_t      instr_q;
   logic [ID_W-1:0]       id_q;

   logic [NUM_REQ-1:0]    gnt;
   logic [ID_W-1:0]       gnt_id;
   logic                  any_gnt;
   logic [FPU_DATA_W-1:0] sel_op1;
   logic [FPU_DATA_W-1:0] sel_op2;
   alu_instruction_t      sel_instr;
   logic [ID_W-1:0]       next_ptr;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .any_gnt (any_gnt)
   );

   // Grants are only offered while idle and never while reset is held.
   assign req_ready = (state == SCH_IDLE && !reset) ? gnt : '0;

   always_comb begin
      int unsigned base;
      base      = 32'(gnt_id);
      sel_op1   = req_op1[base*FPU_DATA_W +: FPU_DATA_W];
      sel_op2   = req_op2[base*FPU_DATA_W +: FPU_DATA_W];
      sel_instr = alu_instruction_t'(req_instr[base*IW +: IW]);
   end

   assign next_ptr = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

   assign alu_op1         = op1_q;
   assign alu_op2         = op2_q;
   assign alu_instruction = instr_q;
   assign resp_id         = id_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SCH_IDLE;
         rr_ptr     <= '0;
         cnt        <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         instr_q    <= alu_instruction_t'('0);
         id_q       <= '0;
         alu_enable <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         unique case (state)
            SCH_IDLE: begin
               if (any_gnt) begin
                  op1_q      <= sel_op1;
                  op2_q      <= sel_op2;
                  instr_q    <= sel_instr;
                  id_q       <= gnt_id;
                  alu_enable <= 1'b1;
                  state      <= SCH_ISSUE;
               end
            end
            SCH_ISSUE: begin
               alu_enable <= 1'b0;
               cnt        <= CNT_W'(ALU_LATENCY);
               state      <= SCH_WAIT;
            end
            SCH_WAIT: begin
               // cnt==1 marks the cycle the ALU result is valid.
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  resp_data  <= alu_result;
                  resp_valid <= 1'b1;
                  state      <= SCH_RESP;
               end
            end
            SCH_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  rr_ptr     <= next_ptr;
                  state      <= SCH_IDLE;
               end
            end
            default: state <= SCH_IDLE;
         endcase
      end
   end

endmodule
